// File: rtl/branch_pred_ctrl_if.sv
// EX-stage branch resolution bus: instruction/prediction info from the
// pipeline and the resulting BTB update and redirect commands.
interface branch_pred_ctrl_if;
  logic        ex_valid;
  logic        ex_stall;
  logic        ex_is_br;
  logic        ex_is_jmp;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_hit;
  logic [31:0] ex_pred_pc;
  logic [1:0]  btb_op;
  logic [31:0] btb_pc;
  logic [31:0] btb_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;

  // Pipeline side: drives the EX instruction, consumes the commands.
  modport master (
    output ex_valid, ex_stall, ex_is_br, ex_is_jmp, ex_taken,
           ex_pc, ex_target, ex_pred_hit, ex_pred_pc,
    input  btb_op, btb_pc, btb_target, redirect, redirect_pc, flush
  );

  // Controller side.
  modport slave (
    input  ex_valid, ex_stall, ex_is_br, ex_is_jmp, ex_taken,
           ex_pc, ex_target, ex_pred_hit, ex_pred_pc,
    output btb_op, btb_pc, btb_target, redirect, redirect_pc, flush
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Branch-prediction controller for EX: checks the IF prediction against the
// resolved outcome, issues BTB insert/invalidate and pipeline redirect/flush,
// keeps a table of 2-bit saturating counters for BTB hysteresis, and counts
// resolved control instructions and mispredictions.
module branch_pred_ctrl #(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  branch_pred_ctrl_if.slave bus,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int DEPTH = 1 << IDX_BITS;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_INVAL  = 2'b01;
  localparam logic [1:0] OP_INSERT = 2'b10;

  cnt_t                tbl [DEPTH];
  logic [IDX_BITS-1:0] idx;
  cnt_t                cnt_cur;
  cnt_t                cnt_new;
  logic                act;
  logic                ctrl;
  logic                actual_taken;
  logic [31:0]         pc_plus4;
  logic [31:0]         pred_next;
  logic [31:0]         actual_next;
  logic                mispredict;
  logic                tgt_differs;
  logic [1:0]          op;

  assign idx     = bus.ex_pc[IDX_BITS+1:2];
  assign cnt_cur = tbl[idx];

  // Resolve the instruction: compare predicted vs actual next PC, compute the
  // saturated counter value and pick the BTB command.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    act          = bus.ex_valid & ~bus.ex_stall & ~rst;
    ctrl         = bus.ex_is_br | bus.ex_is_jmp;
    actual_taken = bus.ex_is_jmp | (bus.ex_is_br & bus.ex_taken);
    pc_plus4     = bus.ex_pc + 32'd4;
    pred_next    = bus.ex_pred_hit ? bus.ex_pred_pc : pc_plus4;
    actual_next  = actual_taken ? bus.ex_target : pc_plus4;
    mispredict   = act & (pred_next != actual_next);
    tgt_differs  = ~bus.ex_pred_hit | (bus.ex_pred_pc != bus.ex_target);

    cnt_new = cnt_cur;
    if (bus.ex_taken) begin
      if (cnt_cur != ST) cnt_new = cnt_t'(cnt_cur + 2'd1);
    end else begin
      if (cnt_cur != SNT) cnt_new = cnt_t'(cnt_cur - 2'd1);
    end

    op = OP_NONE;
    if (act) begin
      if (bus.ex_is_br) begin
        if (bus.ex_taken && cnt_new >= WT && tgt_differs) op = OP_INSERT;
        else if (cnt_new <= WNT && bus.ex_pred_hit)       op = OP_INVAL;
      end else if (bus.ex_is_jmp) begin
        if (tgt_differs) op = OP_INSERT;
      end else if (bus.ex_pred_hit) begin
        op = OP_INVAL;
      end
    end
  end

  // Drive the zero-latency BTB and redirect commands; all zero during reset.
  always_comb begin
    bus.btb_op      = op;
    bus.btb_pc      = rst ? 32'd0 : bus.ex_pc;
    bus.btb_target  = rst ? 32'd0 : bus.ex_target;
    bus.redirect    = mispredict;
    bus.flush       = mispredict;
    bus.redirect_pc = mispredict ? actual_next : 32'd0;
  end

  // Commit counter-table and statistics updates at the end of an active EX cycle.
  // NOTE: the small counter table is reset in full because every entry must
  // start at WNT; larger RAM-style arrays would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= WNT;
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (act) begin
      if (bus.ex_is_br) tbl[idx]    <= cnt_new;
      if (ctrl)         br_cnt      <= br_cnt + 1'b1;
      if (mispredict)   mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench for branch_pred_ctrl: the driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_branch_pred_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  branch_pred_ctrl_if bus ();

  branch_pred_ctrl #(.IDX_BITS(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        redir;
    logic [31:0] rpc;
    logic        flush;
    logic [31:0] brc;
    logic [31:0] mpc;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference state: counter values 0..3 per index, and event counts.
  int          m_tbl [16];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = 1;
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic set_inputs(input bit valid, input bit stall, input bit br, input bit jmp,
                            input bit taken, input logic [31:0] pc, input logic [31:0] tgt,
                            input bit hit, input logic [31:0] ppc);
    bus.ex_valid    = valid;
    bus.ex_stall    = stall;
    bus.ex_is_br    = br;
    bus.ex_is_jmp   = jmp;
    bus.ex_taken    = taken;
    bus.ex_pc       = pc;
    bus.ex_target   = tgt;
    bus.ex_pred_hit = hit;
    bus.ex_pred_pc  = ppc;
  endtask

  // Apply one EX cycle and push the expected response derived from the rules.
  task automatic drive(input bit valid, input bit stall, input bit br, input bit jmp,
                       input bit taken, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit hit, input logic [31:0] ppc);
    exp_t        e;
    bit          act, ctrl, at, mp;
    logic [31:0] pred, actn;
    int          c, cn, ix;
    @(posedge clk);
    #1;
    set_inputs(valid, stall, br, jmp, taken, pc, tgt, hit, ppc);
    act  = valid && !stall;
    ctrl = br || jmp;
    at   = jmp || (br && taken);
    pred = hit ? ppc : pc + 32'd4;
    actn = at ? tgt : pc + 32'd4;
    mp   = act && (pred != actn);
    ix   = int'(pc[5:2]);
    c    = m_tbl[ix];
    cn   = taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
    e.op = 2'd0;
    if (act) begin
      if (br) begin
        if (taken && cn >= 2 && (!hit || ppc != tgt)) e.op = 2'd2;
        else if (cn <= 1 && hit)                      e.op = 2'd1;
      end else if (jmp) begin
        if (!hit || ppc != tgt) e.op = 2'd2;
      end else if (hit) begin
        e.op = 2'd1;
      end
    end
    e.pc    = pc;
    e.tgt   = tgt;
    e.redir = mp;
    e.flush = mp;
    e.rpc   = mp ? actn : 32'd0;
    e.brc   = m_br;
    e.mpc   = m_mp;
    sb_q.push_back(e);
    if (act) begin
      if (br)   m_tbl[ix] = cn;
      if (ctrl) m_br = m_br + 1;
      if (mp)   m_mp = m_mp + 1;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("btb_op",      {30'd0, bus.btb_op}, {30'd0, e.op});
      check("btb_pc",      bus.btb_pc,          e.pc);
      check("btb_target",  bus.btb_target,      e.tgt);
      check("redirect",    {31'd0, bus.redirect}, {31'd0, e.redir});
      check("redirect_pc", bus.redirect_pc,     e.rpc);
      check("flush",       {31'd0, bus.flush},  {31'd0, e.flush});
      check("br_cnt",      br_cnt,              e.brc);
      check("mispred_cnt", mispred_cnt,         e.mpc);
    end
  end

  initial begin
    logic [31:0] pc, tgt, ppc;
    int          kind, pk;
    bit          br, jmp, hit;

    model_reset();
    set_inputs(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #17;
    check("reset br_cnt",      br_cnt,      32'd0);
    check("reset mispred_cnt", mispred_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Taken branch, no hit: WNT->WT, insert, redirect to 0x80.
    drive(1, 0, 1, 0, 1, 32'h40, 32'h80, 0, 32'h0);
    // Taken again with correct hit: WT->ST, no action.
    drive(1, 0, 1, 0, 1, 32'h40, 32'h80, 1, 32'h80);
    // Not taken from ST: keep entry, redirect to 0x44.
    drive(1, 0, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80);
    idle();
    // Not taken from WT: invalidate.
    drive(1, 0, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80);
    idle();
    // Jump with wrong predicted target.
    drive(1, 0, 0, 1, 1, 32'h100, 32'h200, 1, 32'h1F0);
    idle();
    // Non-control with stale hit.
    drive(1, 0, 0, 0, 0, 32'h24, 32'h0, 1, 32'h300);
    idle();
    // Mispredicting branch stalled three cycles, then released once.
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 1, 32'h48, 32'h400, 0, 32'h0);
    drive(1, 0, 1, 0, 1, 32'h48, 32'h400, 0, 32'h0);
    idle();

    // Randomized traffic over a few colliding PCs.
    for (int n = 0; n < 400; n++) begin
      pc   = 32'h1000 + ({27'd0, 5'($urandom_range(0, 7))} << 2);
      tgt  = 32'h2000 + ({24'd0, 8'($urandom_range(0, 3))} << 4);
      kind = $urandom_range(0, 3);
      br   = (kind == 1 || kind == 2);
      jmp  = (kind == 3);
      hit  = $urandom_range(0, 1) == 1;
      pk   = $urandom_range(0, 2);
      ppc  = (pk == 0) ? tgt : (pk == 1) ? pc + 32'd4 : $urandom;
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, br, jmp,
            $urandom_range(0, 1) == 1, pc, tgt, hit, ppc);
    end
    idle();

    // Statistics wrap: preload mispred_cnt to all-ones, then one mispredict.
    @(negedge clk);
    #1;
    force dut.mispred_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt;
    m_mp = 32'hFFFF_FFFF;
    drive(1, 0, 0, 1, 1, 32'h500, 32'h600, 0, 32'h0);
    idle();
    idle();

    // Push index of 0x40 to ST, then reset asynchronously mid-cycle.
    drive(1, 0, 1, 0, 1, 32'h40, 32'h80, 1, 32'h80);
    drive(1, 0, 1, 0, 1, 32'h40, 32'h80, 1, 32'h80);
    idle();
    @(negedge clk);
    #2;
    set_inputs(1, 0, 1, 0, 1, 32'h40, 32'h900, 0, 32'h0);
    rst = 1'b1;
    #1;
    check("async rst br_cnt",      br_cnt,          32'd0);
    check("async rst mispred_cnt", mispred_cnt,     32'd0);
    check("rst btb_op",            {30'd0, bus.btb_op}, 32'd0);
    check("rst redirect",          {31'd0, bus.redirect}, 32'd0);
    check("rst flush",             {31'd0, bus.flush}, 32'd0);
    check("rst redirect_pc",       bus.redirect_pc, 32'd0);
    check("rst btb_pc",            bus.btb_pc,      32'd0);
    set_inputs(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // Not taken with hit: from reset WNT->SNT invalidates (from ST it would not).
    drive(1, 0, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80);
    idle();

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_pred_ctrl.md
# branch_pred_ctrl

Branch-prediction controller for the EX stage of the pipelined CPU. It compares the prediction carried down from IF with the branch outcome resolved in EX. From that it produces the branch target buffer update command (insert / invalidate / none), the pipeline redirect and flush, and misprediction statistics. A 16-entry table of 2-bit saturating counters gives hysteresis, so one anomalous not-taken branch does not evict a hot BTB entry.

## Interface
- IDX_BITS, 4: counter-table index width; table has 2^IDX_BITS entries, indexed by ex_pc[IDX_BITS+1:2] (same mapping as the BTB).
- CNT_W, 32: width of the statistics counters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- ex_valid  in  1  EX holds a real instruction (0 = bubble).
- ex_stall  in  1  EX is held this cycle; no action, no state change.
- ex_is_br  in  1  EX instruction is a conditional branch.
- ex_is_jmp  in  1  EX instruction is an unconditional direct jump (always taken).
- ex_taken  in  1  resolved branch direction (ignored unless ex_is_br).
- ex_pc  in  32  PC of the EX instruction.
- ex_target  in  32  resolved taken target.
- ex_pred_hit  in  1  BTB hit recorded in IF for this instruction.
- ex_pred_pc  in  32  BTB-predicted PC recorded in IF (valid only when ex_pred_hit).
- btb_op  out  2  BTB command: 2'b10 insert/overwrite, 2'b01 invalidate, 2'b00 none.
- btb_pc  out  32  PC to update; equals ex_pc.
- btb_target  out  32  target to write; equals ex_target.
- redirect  out  1  misprediction: fetch must restart at redirect_pc.
- redirect_pc  out  32  correct next PC.
- flush  out  1  squash IF/ID and ID/EX; equals redirect.
- br_cnt  out  CNT_W  resolved control instructions since reset.
- mispred_cnt  out  CNT_W  mispredictions since reset.

## Operation
- act = ex_valid & !ex_stall & !rst. When act=0: btb_op=00, redirect=0, flush=0, no table or counter change.
- ctrl = ex_is_br | ex_is_jmp. actual_taken = ex_is_jmp | (ex_is_br & ex_taken).
- pred_next = ex_pred_hit ? ex_pred_pc : ex_pc+4. actual_next = actual_taken ? ex_target : ex_pc+4. All additions are mod 2^32.
- mispredict = act & (pred_next != actual_next). This includes a non-control instruction with a stale BTB hit. redirect = flush = mispredict; redirect_pc = actual_next (0 when not redirecting).
- Counter table: states SNT=00, WNT=01, WT=10, ST=11; reset value WNT for every entry.
- For an active conditional branch, cnt_new = taken ? min(cnt+1,3) : max(cnt-1,0), written at the clock edge. Jumps and non-control instructions do not touch the table.
- btb_op when act:
  - Conditional branch with ex_taken and cnt_new>=WT, and (!ex_pred_hit or ex_pred_pc!=ex_target) → 10.
  - Conditional branch with cnt_new<=WNT and ex_pred_hit → 01.
  - Jump with (!ex_pred_hit or ex_pred_pc!=ex_target) → 10.
  - Non-control instruction with ex_pred_hit → 01.
  - Otherwise → 00.
  - Consequence: a not-taken branch going ST→WT keeps its entry (redirect still fires). A taken branch going SNT→WNT does not insert (redirect still fires).
- br_cnt += 1 when act & ctrl. mispred_cnt += 1 when mispredict. Both wrap at 2^CNT_W.

## Timing
- btb_op, btb_pc, btb_target, redirect, redirect_pc and flush are combinational from the EX inputs and current table state, valid in the same EX cycle. Zero latency, matching the combinational BTB write.
- Counter table and statistics update on the rising edge that ends the EX cycle. A same-index branch in the next cycle sees the updated counter.
- Reset values: all table entries 01; br_cnt=0, mispred_cnt=0. While rst=1, all combinational outputs are 0.
- Reset asserted mid-operation clears state immediately (asynchronous), regardless of clk or stall.
- Stall held N cycles: outputs stay 0 and state is frozen; the action occurs once, in the cycle ex_stall drops.
- The cycle after a redirect, EX holds a bubble (ex_valid=0) and must produce no action.

## Test plan
- After reset, branch at ex_pc=0x40, taken, target 0x80, no hit → redirect=1, redirect_pc=0x80, btb_op=00 (counter 01→10 gives cnt_new=WT, so this is wrong; see corrected expectation below).
  - Corrected: counter 01→10, btb_op=10, br_cnt=1, mispred_cnt=1.
- Same PC, counter at ST, hit with pred 0x80, not taken → redirect_pc=0x44, btb_op=00, counter becomes WT. A second not-taken → btb_op=01, counter becomes WNT.
- Jump at 0x100, target 0x200, hit with pred 0x1F0 → btb_op=10, redirect_pc=0x200.
- Non-branch at 0x24 with stale hit to 0x300 → btb_op=01, redirect_pc=0x28, br_cnt unchanged, mispred_cnt +1.
- Mispredicting branch held with ex_stall=1 for 3 cycles → no outputs or counts until the stall drops, then exactly one redirect.
- Preload mispred_cnt to 2^CNT_W-1 (force), then one mispredict → wraps to 0. Assert rst mid-cycle → table and counters clear without a clock edge.
